bit_pattern_gen: RTL and testbench

BIT_PATTERN_GEN -- requirements
Module: bit_pattern_gen

---
 rtl/bit_pattern_gen.sv | 85 ++++++++
 tb/tb_bit_pattern_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bit_pattern_gen.sv
// bit_pattern_gen: builds an LSB-justified run of ones, one bit per clock.
// start launches a build; done stays up until start is released.
module bit_pattern_gen #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       count_in,
    output logic             busy,
    output logic             z,
    output logic             done,
    output logic [width-1:0] pattern
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [3:0]       WMAX = 4'(width);
    localparam logic [width-1:0] ONE  = width'(1);

    state_t           state;
    state_t           state_nx;
    logic [width-1:0] sr;
    logic [width-1:0] sr_nx;
    logic [3:0]       rem;
    logic [3:0]       rem_nx;
    logic [3:0]       load_cnt;

    // requests wider than the word saturate to an all-ones pattern
    assign load_cnt = (count_in > WMAX) ? WMAX : count_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            sr    <= '0;
            rem   <= '0;
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
            rem   <= rem_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        rem_nx   = rem;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_SHIFT;
                    sr_nx    = '0;
                    rem_nx   = load_cnt;
                end
            end
            S_SHIFT: begin
                if (rem != 4'd0) begin
                    // shift form also covers width == 1
                    sr_nx  = (sr << 1) | ONE;
                    rem_nx = rem - 4'd1;
                end else begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign busy    = (state == S_SHIFT);
    assign done    = (state == S_DONE);
    assign z       = (rem == 4'd0);
    assign pattern = done ? sr : '0;

endmodule

// File: tb/tb_bit_pattern_gen.sv
// tb_bit_pattern_gen: directed builds with a queued scoreboard.
// A negedge monitor checks every completion and the idle/done outputs.
module tb_bit_pattern_gen;

    typedef struct {
        logic [7:0] pat;
        int         busy_cycles;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] count_in;
    logic       busy;
    logic       z;
    logic       done;
    logic [7:0] pattern;

    int   tests;
    int   fails;
    exp_t q[$];
    exp_t cur;
    int   bcnt;
    logic done_q;
    logic mon_on;

    bit_pattern_gen #(.width(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .count_in (count_in),
        .busy     (busy),
        .z        (z),
        .done     (done),
        .pattern  (pattern)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_on) begin
            if (busy) bcnt++;
            if (done && !done_q) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    cur = q.pop_front();
                    chk("busy_cycles", bcnt, cur.busy_cycles);
                end
            end
            if (done) begin
                chk("pattern_done", int'(pattern), int'(cur.pat));
                chk("z_in_done", int'(z), 1);
                chk("busy_in_done", int'(busy), 0);
            end else begin
                chk("pattern_not_done", int'(pattern), 0);
            end
            if (!busy && !done) bcnt = 0;
            done_q = done;
        end
    end

    task automatic wait_level(input logic lvl, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done == lvl) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk(name, 0, 1);
    endtask

    task automatic build(input logic [3:0] c, input logic [3:0] c_late,
                         input int hold, input logic [7:0] exp_pat,
                         input int exp_busy);
        exp_t e;
        e.pat         = exp_pat;
        e.busy_cycles = exp_busy;
        q.push_back(e);
        @(negedge clk);
        start    = 1'b1;
        count_in = c;
        @(negedge clk);
        count_in = c_late;
        repeat (hold - 1) @(negedge clk);
        start = 1'b0;
        wait_level(1'b1, "done_timeout");
        if (hold > 1) begin
            @(negedge clk);
            chk("release_done", int'(done), 0);
            chk("release_busy", int'(busy), 0);
        end
        wait_level(1'b0, "idle_timeout");
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests    = 0;
        fails    = 0;
        bcnt     = 0;
        done_q   = 1'b0;
        mon_on   = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        count_in = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_z", int'(z), 1);
        chk("reset_pattern", int'(pattern), 0);
        mon_on = 1'b1;

        build(4'd5,  4'd5,  1,  8'h1F, 6);
        build(4'd0,  4'd0,  1,  8'h00, 1);
        build(4'd8,  4'd8,  1,  8'hFF, 9);
        build(4'd13, 4'd13, 1,  8'hFF, 9);
        build(4'd3,  4'd3,  20, 8'h07, 4);
        build(4'd6,  4'd2,  1,  8'h3F, 7);

        // abandon a count 7 build on its third shift cycle
        @(negedge clk);
        start    = 1'b1;
        count_in = 4'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_z", int'(z), 1);
        @(negedge clk);
        chk("abort_stays_idle", int'(busy), 0);

        build(4'd2, 4'd2, 1, 8'h03, 3);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
